// File: rtl/mux_op_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_op_arbiter_if
// Brief    : Requester-side and datapath-unit-side bundle of mux_op_arbiter.
// Revision : 1.0
// ============================================================================
interface mux_op_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_b;
    logic [N_REQ*SEL_W-1:0]  req_s;
    logic [N_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]       resp_data;
    logic                    resp_err;
    logic                    busy;
    logic [DATA_W-1:0]       op_a;
    logic [DATA_W-1:0]       op_b;
    logic [SEL_W-1:0]        op_s;
    logic                    op_r_ready;
    logic [DATA_W-1:0]       op_ans;
    logic                    op_w_ready;

    modport slave (
        input  req_valid, req_a, req_b, req_s, op_ans, op_w_ready,
        output req_ready, resp_valid, resp_data, resp_err, busy,
               op_a, op_b, op_s, op_r_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_s, op_ans, op_w_ready,
        input  req_ready, resp_valid, resp_data, resp_err, busy,
               op_a, op_b, op_s, op_r_ready
    );
endinterface
`default_nettype wire

// File: rtl/mux_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_op_arbiter
// Brief    : Round-robin arbiter/sequencer sharing one mux_operation unit,
//            with a watchdog that aborts hung operations.
// Revision : 1.0
// ============================================================================
module mux_op_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mux_op_arbiter_if.slave   bus
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [PTR_W-1:0] C_LAST    = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  r_gnt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [SEL_W-1:0]  r_op_s;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_err;
    logic [N_REQ-1:0]  r_resp_valid;

    logic [PTR_W-1:0]  w_gnt;
    logic              w_found;
    logic [CNT_W-1:0]  w_cnt_next;

    // First set request at or above r_ptr, wrapping modulo N_REQ.
    always_comb begin : p_grant
        int v_idx;
        w_found = 1'b0;
        w_gnt   = '0;
        v_idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            v_idx = int'(r_ptr) + i;
            if (v_idx >= N_REQ) begin
                v_idx = v_idx - N_REQ;
            end
            if (!w_found && bus.req_valid[PTR_W'(v_idx)]) begin
                w_found = 1'b1;
                w_gnt   = PTR_W'(v_idx);
            end
        end
    end

    assign w_cnt_next = r_cnt + 1'b1;

    // The accept strobe is combinational, so it is gated by rst to stay 0 in reset.
    assign bus.req_ready  = (r_state == S_IDLE && w_found && !rst) ?
                            (N_REQ'(1) << w_gnt) : '0;
    assign bus.op_r_ready = (r_state == S_ISSUE) && !bus.op_w_ready;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.op_a       = r_op_a;
    assign bus.op_b       = r_op_b;
    assign bus.op_s       = r_op_s;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_err   = r_resp_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_gnt        <= '0;
            r_cnt        <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_s       <= '0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_resp_valid <= '0;
        end else begin
            r_resp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt   <= w_gnt;
                        r_op_a  <= bus.req_a[int'(w_gnt)*DATA_W +: DATA_W];
                        r_op_b  <= bus.req_b[int'(w_gnt)*DATA_W +: DATA_W];
                        r_op_s  <= bus.req_s[int'(w_gnt)*SEL_W +: SEL_W];
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // A result still showing from before must clear before starting.
                    if (!bus.op_w_ready) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_next;
                    if (bus.op_w_ready) begin
                        r_resp_data  <= bus.op_ans;
                        r_resp_err   <= 1'b0;
                        r_resp_valid <= N_REQ'(1) << r_gnt;
                        r_state      <= S_RESP;
                    end else if (w_cnt_next == C_TIMEOUT) begin
                        r_resp_data  <= '0;
                        r_resp_err   <= 1'b1;
                        r_resp_valid <= N_REQ'(1) << r_gnt;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_ptr   <= (r_gnt == C_LAST) ? '0 : r_gnt + 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mux_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_op_arbiter
// Brief    : Scoreboard bench for mux_op_arbiter with a behavioural unit model.
// Revision : 1.0
// ============================================================================
module tb_mux_op_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 8;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        logic          err;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_op_arbiter_if #(.N_REQ(N), .DATA_W(DW), .SEL_W(SW)) bus ();

    mux_op_arbiter #(.N_REQ(N), .DATA_W(DW), .SEL_W(SW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    exp_t          exp_q[$];
    int            act_rr[$];
    int            rem[N];
    logic [DW-1:0] a_arr[N];
    logic [DW-1:0] b_arr[N];
    logic [SW-1:0] s_arr[N];
    int            model_ptr = 0;
    int            unit_lat = 2;
    int            cur_lat = 2;
    bit            lat_mode = 1'b0;
    bit            stale_force = 1'b0;
    bit            r_seen = 1'b0;
    int            cd = 0;
    int            exp_rr = -1;
    int            rr_cnt = 0;
    bit            pending_upd = 1'b0;
    int            acc_g = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]         = (rem[i] > 0);
            bus.req_a[i*DW +: DW]    = a_arr[i];
            bus.req_b[i*DW +: DW]    = b_arr[i];
            bus.req_s[i*SW +: SW]    = s_arr[i];
        end
    end

    // Behaviour of the shared unit: result = A+B for S=6, else A ^ (B+S).
    function automatic logic [DW-1:0] ref_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [SW-1:0] s);
        return (s == 4'd6) ? (a + b) : (a ^ (b + DW'(s)));
    endfunction

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int j;
            j = (model_ptr + k) % N;
            if (rem[j] > 0) return j;
        end
        return -1;
    endfunction

    function automatic int sum_rem();
        int t;
        t = 0;
        for (int k = 0; k < N; k++) t += rem[k];
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  bus.req_ready, 0);
        check({tag, "_resp_valid"}, bus.resp_valid, 0);
        check({tag, "_resp_data"},  bus.resp_data, 0);
        check({tag, "_resp_err"},   bus.resp_err, 0);
        check({tag, "_busy"},       bus.busy, 0);
        check({tag, "_op_a"},       bus.op_a, 0);
        check({tag, "_op_b"},       bus.op_b, 0);
        check({tag, "_op_s"},       bus.op_s, 0);
        check({tag, "_op_r_ready"}, bus.op_r_ready, 0);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((sum_rem() > 0 || exp_q.size() > 0 || bus.busy) && n < 3000) begin
            @(posedge clk); #2;
            n++;
        end
        check({"complete_", name}, (n < 3000), 1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    // Unit model: w_ready pulses cur_lat cycles after the r_ready cycle; 0 = never.
    initial begin
        bus.op_w_ready = 1'b0;
        bus.op_ans     = '0;
        forever begin : unit_loop
            logic w;
            @(posedge clk); #1;
            w = 1'b0;
            if (rst) begin
                cd = 0;
            end else begin
                if (r_seen) begin
                    r_seen = 1'b0;
                    cd     = cur_lat;
                end
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        w = 1'b1;
                        bus.op_ans = ref_f(bus.op_a, bus.op_b, bus.op_s);
                    end
                end
            end
            bus.op_w_ready = w | stale_force;
        end
    end

    // Requester update after an accept: consume one transaction, fresh operands.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (pending_upd) begin
                rem[acc_g]   = rem[acc_g] - 1;
                a_arr[acc_g] = $urandom;
                b_arr[acc_g] = $urandom;
                s_arr[acc_g] = SW'($urandom_range(0, 15));
                pending_upd  = 1'b0;
            end
        end
    end

    // Monitor/scoreboard plus accept tracking, sampled mid-cycle.
    initial begin
        forever begin : mon_loop
            exp_t e;
            int   g;
            @(negedge clk);
            if (rst) begin
                r_seen = 1'b0;
                continue;
            end
            if (bus.op_r_ready) begin
                rr_cnt++;
                r_seen = 1'b1;
                if (exp_rr >= 0) check("op_r_ready_cycle", cyc, exp_rr);
                else if (exp_rr == -1) check("op_r_ready_extra", bus.op_r_ready, 0);
                exp_rr = -1;
            end
            if (bus.resp_valid != 0) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", bus.resp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_valid_onehot", bus.resp_valid, 64'(1) << e.idx);
                    check("resp_data", bus.resp_data, e.data);
                    check("resp_err", bus.resp_err, e.err);
                    check("busy_in_resp", bus.busy, 1);
                    if (e.cyc >= 0) check("resp_cycle", cyc, e.cyc);
                end
            end
            if (bus.req_ready != 0) begin
                g = model_grant();
                act_rr.push_back(int'(bus.req_ready));
                if (g < 0) begin
                    check("req_ready_unexpected", bus.req_ready, 0);
                end else begin
                    check("grant", bus.req_ready, 64'(1) << g);
                    if (lat_mode)
                        cur_lat = ($urandom_range(0, 8) == 0) ? 0 : int'($urandom_range(1, TO));
                    else
                        cur_lat = unit_lat;
                    e.idx  = g;
                    e.err  = (cur_lat == 0);
                    e.data = e.err ? '0 : ref_f(a_arr[g], b_arr[g], s_arr[g]);
                    e.cyc  = stale_force ? -1 : cyc + 2 + (e.err ? TO : cur_lat);
                    exp_q.push_back(e);
                    exp_rr      = stale_force ? -2 : cyc + 1;
                    model_ptr   = (g + 1) % N;
                    acc_g       = g;
                    pending_upd = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int rr0;
        int n;
        for (int i = 0; i < N; i++) begin
            rem[i]   = 0;
            a_arr[i] = $urandom;
            b_arr[i] = $urandom;
            s_arr[i] = SW'($urandom_range(0, 15));
        end
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("por");
        #2 rst = 1'b0;
        @(posedge clk); #2;

        // Round-robin with all requesters continuously valid.
        act_rr.delete();
        unit_lat = 1;
        for (int i = 0; i < N; i++) begin
            rem[i]   = 2;
            a_arr[i] = DW'(100 + i);
        end
        wait_idle("round_robin");
        for (int k = 0; k < 5; k++) check("rr_order", act_rr[k], 1 << (k % N));

        // Single request (ptr wraps back to 0 after the full rotation).
        a_arr[0] = 32'd10; b_arr[0] = 32'd20; s_arr[0] = 4'd6;
        unit_lat = 2;
        rem[0]   = 1;
        wait_idle("single");
        check("single_result_hold", bus.resp_data, 32'h1E);

        // Timeout, then a normal request.
        unit_lat = 0;
        rem[1]   = 1;
        wait_idle("timeout");
        check("timeout_err_hold", bus.resp_err, 1);
        unit_lat = 3;
        rem[3]   = 1;
        wait_idle("after_timeout");

        // Success arriving in the same cycle as the timeout.
        unit_lat = TO;
        rem[2]   = 1;
        wait_idle("simultaneous");

        // Stale w_ready held across the accept.
        unit_lat    = 2;
        stale_force = 1'b1;
        rem[0]      = 1;
        rr0         = rr_cnt;
        repeat (6) @(posedge clk);
        #2 check("stale_no_r_ready", rr_cnt, rr0);
        stale_force = 1'b0;
        wait_idle("stale");
        check("stale_one_pulse", rr_cnt, rr0 + 1);

        // Reset during WAIT, pointer left at a non-zero value beforehand.
        rem[0] = 1;
        wait_idle("pre_reset");
        unit_lat = 0;
        rem[2]   = 1;
        n = 0;
        while (!bus.busy && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        repeat (4) @(posedge clk);
        #2 check("busy_before_reset", bus.busy, 1);
        #1 rst = 1'b1;
        #1 check_reset_outputs("mid_wait");
        exp_q.delete();
        model_ptr = 0;
        exp_rr    = -1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        unit_lat = 2;
        rem[0]   = 1;
        rem[1]   = 1;
        wait_idle("post_reset");

        // Randomized traffic.
        lat_mode = 1'b1;
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < N; i++) rem[i] = int'($urandom_range(0, 3));
            rem[$urandom_range(0, N - 1)] += 1;
            wait_idle("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
